// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blink_pkg
//  Description : Shared state encoding and default constants for the Blink
//                game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package blink_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_PLAY = 3'd2,
        S_MISS = 3'd3,
        S_OVER = 3'd4
    } game_state_t;

    localparam int c_arm_ticks      = 4;
    localparam int c_miss_ticks     = 2;
    localparam int c_hits_per_level = 8;
    localparam int c_lives          = 3;

endpackage
`default_nettype wire

// File: rtl/blink_game_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Loadable down-counter advanced by tick; done flags a tick
//                that arrives with the count already at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = tick && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/blink_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : blink_game_ctrl
//  Description : Moore game controller sequencing IDLE/ARM/PLAY/MISS/OVER,
//                keeping score, level and lives. BLINK_LIVES_EN enables the
//                multi-life MISS phase; without it a loss ends the game.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_game_ctrl
    import blink_pkg::*;
#(
    parameter int SCORE_W        = 8,
    parameter int LEVEL_W        = 4,
    parameter int HITS_PER_LEVEL = c_hits_per_level,
    parameter int LIVES          = c_lives,
    parameter int ARM_TICKS      = c_arm_ticks,
    parameter int MISS_TICKS     = c_miss_ticks
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick,
    input  logic               hit,
    input  logic               lose,
    output logic               check_en,
    output logic               clr_det,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         lives,
    output logic               game_over
);

    localparam int c_max_ticks = (ARM_TICKS > MISS_TICKS) ? ARM_TICKS : MISS_TICKS;
    localparam int c_tw        = $clog2(c_max_ticks + 1);
    localparam int c_hcw       = $clog2(HITS_PER_LEVEL + 1);

    game_state_t        r_state;
    game_state_t        w_next;
    logic               r_lose_q;
    logic               r_clr_det;
    logic [SCORE_W-1:0] r_score;
    logic [LEVEL_W-1:0] r_level;
    logic [c_hcw-1:0]   r_hit_cnt;
    logic               w_lose_edge;
    logic               w_fresh;
    logic               w_timer_load;
    logic [c_tw-1:0]    w_timer_val;
    logic               w_timer_done;

    assign w_lose_edge = lose && !r_lose_q;
    assign w_fresh     = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;

    phase_timer #(
        .W (c_tw)
    ) u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .tick     (tick),
        .done     (w_timer_done)
    );

`ifdef BLINK_LIVES_EN
    logic [1:0] r_lives;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lives <= 2'd0;
        end else if (w_fresh) begin
            r_lives <= 2'(LIVES);
        end else if ((r_state == S_PLAY) && w_lose_edge && (r_lives != 2'd0)) begin
            r_lives <= r_lives - 2'd1;
        end
    end

    assign lives = r_lives;
`else
    assign lives = 2'd0;
`endif

    always_comb begin
        w_next       = r_state;
        w_timer_load = 1'b0;
        w_timer_val  = c_tw'(ARM_TICKS - 1);
        case (r_state)
            S_IDLE: if (start) w_next = S_ARM;
            S_ARM:  if (w_timer_done) w_next = S_PLAY;
`ifdef BLINK_LIVES_EN
            S_PLAY: if (w_lose_edge) w_next = S_MISS;
            // r_lives already holds the post-loss value while in MISS
            S_MISS: begin
                if (r_lives == 2'd0) begin
                    w_next = S_OVER;
                end else if (w_timer_done) begin
                    w_next = S_ARM;
                end
            end
`else
            S_PLAY: if (w_lose_edge) w_next = S_OVER;
            S_MISS: w_next = S_OVER;
`endif
            S_OVER: if (start) w_next = S_ARM;
            default: w_next = S_IDLE;
        endcase

        if ((w_next == S_ARM) && (r_state != S_ARM)) begin
            w_timer_load = 1'b1;
        end
`ifdef BLINK_LIVES_EN
        if ((w_next == S_MISS) && (r_state != S_MISS)) begin
            w_timer_load = 1'b1;
            w_timer_val  = c_tw'(MISS_TICKS - 1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_lose_q  <= 1'b0;
            r_clr_det <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_lose_q  <= lose;
            r_clr_det <= (w_next == S_ARM) && (r_state != S_ARM);
        end
    end

    // A loss edge in the same cycle as a hit discards the hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score   <= '0;
            r_level   <= '0;
            r_hit_cnt <= '0;
        end else if (w_fresh) begin
            r_score   <= '0;
            r_level   <= '0;
            r_hit_cnt <= '0;
        end else if ((r_state == S_PLAY) && hit && !w_lose_edge) begin
            if (r_score != '1) begin
                r_score <= r_score + 1'b1;
            end
            if (r_hit_cnt == c_hcw'(HITS_PER_LEVEL - 1)) begin
                r_hit_cnt <= '0;
                if (r_level != '1) begin
                    r_level <= r_level + 1'b1;
                end
            end else begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign score     = r_score;
    assign level     = r_level;
    assign check_en  = (r_state == S_PLAY);
    assign clr_det   = r_clr_det;
    assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_blink_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_game_ctrl
//  Description : Directed scoreboard bench for blink_game_ctrl; expectations
//                follow BLINK_LIVES_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_game_ctrl;

    localparam int ARM_T = 4;
    localparam int MISS_T = 2;
    localparam int HPL = 8;
    localparam int LIV = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       hit = 1'b0;
    logic       lose = 1'b0;
    logic       check_en;
    logic       clr_det;
    logic [2:0] state;
    logic [7:0] score;
    logic [3:0] level;
    logic [1:0] lives;
    logic       game_over;

    always #5 clk = ~clk;

    blink_game_ctrl #(
        .SCORE_W        (8),
        .LEVEL_W        (4),
        .HITS_PER_LEVEL (HPL),
        .LIVES          (LIV),
        .ARM_TICKS      (ARM_T),
        .MISS_TICKS     (MISS_T)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .tick      (tick),
        .hit       (hit),
        .lose      (lose),
        .check_en  (check_en),
        .clr_det   (clr_det),
        .state     (state),
        .score     (score),
        .level     (level),
        .lives     (lives),
        .game_over (game_over)
    );

    typedef struct {
        string tag;
        int    st;
        int    sc;
        int    lv;
        int    li;
        int    ce;
        int    cd;
        int    go;
    } exp_t;

    exp_t q_exp[$];
    int   n_run = 0;
    int   n_fail = 0;

    // Reference model: total hits this game, ticks still owed, lives left
    int   m_st;
    int   m_hits;
    int   m_rem;
    int   m_lives;
    bit   m_clr;
    bit   m_prev_lose;
    bit   g_lose = 1'b0;

    function automatic void model_reset();
        m_st = 0; m_hits = 0; m_rem = 0; m_lives = 0; m_clr = 1'b0; m_prev_lose = 1'b0;
    endfunction

    function automatic void model_step(bit s, bit t, bit h, bit l);
        bit le;
        le = l && !m_prev_lose;
        m_prev_lose = l;
        m_clr = 1'b0;
        case (m_st)
            0, 4: if (s) begin
`ifdef BLINK_LIVES_EN
                m_lives = LIV;
`else
                m_lives = 0;
`endif
                m_st = 1; m_hits = 0; m_rem = ARM_T; m_clr = 1'b1;
            end
            1: if (t) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_st = 2;
            end
            2: if (le) begin
`ifdef BLINK_LIVES_EN
                m_lives = m_lives - 1; m_st = 3; m_rem = MISS_T;
`else
                m_st = 4;
`endif
            end else if (h) begin
                m_hits = m_hits + 1;
            end
            3: if (m_lives == 0) begin
                m_st = 4;
            end else if (t) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_st = 1; m_rem = ARM_T; m_clr = 1'b1;
                end
            end
            default: m_st = 0;
        endcase
    endfunction

    task automatic push_exp(string tag);
        exp_t e;
        e.tag = tag;
        e.st  = m_st;
        e.sc  = (m_hits > 255) ? 255 : m_hits;
        e.lv  = ((m_hits / HPL) > 15) ? 15 : (m_hits / HPL);
        e.li  = m_lives;
        e.ce  = (m_st == 2) ? 1 : 0;
        e.cd  = m_clr ? 1 : 0;
        e.go  = (m_st == 4) ? 1 : 0;
        q_exp.push_back(e);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        n_run++;
        assert (q_exp.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = q_exp.pop_front();
        chk({e.tag, ".state"},     32'(state),     32'(e.st));
        chk({e.tag, ".score"},     32'(score),     32'(e.sc));
        chk({e.tag, ".level"},     32'(level),     32'(e.lv));
        chk({e.tag, ".lives"},     32'(lives),     32'(e.li));
        chk({e.tag, ".check_en"},  32'(check_en),  32'(e.ce));
        chk({e.tag, ".clr_det"},   32'(clr_det),   32'(e.cd));
        chk({e.tag, ".game_over"}, 32'(game_over), 32'(e.go));
    endtask

    // Called just after a rising edge: drive, predict, clock, compare
    task automatic step(string tag, bit s, bit t, bit h);
        start = s; tick = t; hit = h; lose = g_lose;
        model_step(s, t, h, g_lose);
        push_exp(tag);
        @(posedge clk);
        #1;
        check_out();
        start = 1'b0; tick = 1'b0; hit = 1'b0;
    endtask

    task automatic arm_run(string tag);
        step({tag, "_arm0"}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ARM_T; i++) begin
            step({tag, "_armtick"}, 1'b0, 1'b1, 1'b0);
            if (i < ARM_T - 1) step({tag, "_armgap"}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic miss_run(string tag);
        step({tag, "_miss_start"}, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MISS_T; i++) begin
            step({tag, "_misstick"}, 1'b0, 1'b1, 1'b0);
            if (i < MISS_T - 1) step({tag, "_missgap"}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        #12;
        push_exp("reset");
        check_out();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        step("idle_ignore", 1'b0, 1'b1, 1'b1);
        step("start", 1'b1, 1'b0, 1'b0);
        step("arm_ign_start", 1'b1, 1'b0, 1'b0);
        arm_run("g1");
        for (int i = 0; i < 5; i++) step("hit5", 1'b0, 1'b0, 1'b1);
        g_lose = 1'b1;
        step("hit_and_lose", 1'b0, 1'b0, 1'b1);

`ifdef BLINK_LIVES_EN
        miss_run("l1");
        arm_run("l1");
        step("play_lose_held", 1'b0, 1'b0, 1'b0);
        g_lose = 1'b0;
        for (int i = 0; i < 3; i++) step("hit3", 1'b0, 1'b0, 1'b1);
        g_lose = 1'b1;
        step("lose2", 1'b0, 1'b0, 1'b0);
        miss_run("l2");
        g_lose = 1'b0;
        arm_run("l2");
        g_lose = 1'b1;
        step("lose3", 1'b0, 1'b0, 1'b0);
        step("to_over", 1'b0, 1'b1, 1'b0);
`endif

        step("over_frozen", 1'b0, 1'b1, 1'b1);
        g_lose = 1'b0;
        step("restart", 1'b1, 1'b0, 1'b0);
        arm_run("g2");
        for (int i = 0; i < 260; i++) step("hit_sat", 1'b0, 1'b0, 1'b1);

        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        push_exp("async_reset");
        check_out();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp("post_reset");
        check_out();
        step("start_after_reset", 1'b1, 1'b0, 1'b0);
        step("arm_after_reset", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
